// File: rtl/d05200_otp_ctrl.sv
// OTP access controller: boot-loads LCFR/HCFR/HL_SEL trims, then serves single-byte host read/program requests.
// Latency: read SU_CYC+RD_CYC+2 edges, program SU_CYC+PG_CYC+2 edges (+SU_CYC+RD_CYC+1 with OTP_VERIFY_EN read-back).
// Backpressure: REQ_RDY only in IDLE after boot; one access in flight. Macro OTP_VERIFY_EN enables program read-back verify.
module d05200_otp_ctrl #(
    parameter int         SU_CYC    = 2,
    parameter int         RD_CYC    = 4,
    parameter int         PG_CYC    = 200,
    parameter logic [6:0] LCFR_ADDR = 7'h00,
    parameter logic [6:0] HCFR_ADDR = 7'h01,
    parameter logic [6:0] CFG_ADDR  = 7'h02
) (
    input  logic       LCLK,
    input  logic       RESET,
    input  logic       REQ_VLD,
    output logic       REQ_RDY,
    input  logic       REQ_WR,
    input  logic [6:0] REQ_ADDR,
    input  logic [7:0] REQ_WDAT,
    output logic       RSP_VLD,
    output logic [7:0] RSP_DAT,
    output logic       RSP_ERR,
    output logic       OTP_CS,
    output logic       OTP_READ,
    output logic       OTP_PROG,
    output logic [6:0] OTP_ADDR,
    output logic [7:0] OTP_DATI,
    input  logic [7:0] OTP_DATO,
    output logic [7:0] LCFR,
    output logic [7:0] HCFR,
    output logic       HL_SEL,
    output logic       BOOT_DONE
);

`ifdef OTP_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    localparam logic [7:0] SU_LD = 8'(SU_CYC - 1);
    localparam logic [7:0] RD_LD = 8'(RD_CYC - 1);
    localparam logic [7:0] PG_LD = 8'(PG_CYC - 1);

    typedef enum logic [2:0] {SETUP, READ, PROG, HOLD, IDLE} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [1:0] boot_idx;
    logic       acc_wr, vfy_phase;
    logic [6:0] addr_q;
    logic [7:0] wdat_q, rd_q, lcfr_tmp, hcfr_tmp;
    logic       hs, prog_phase, boot_next, boot_end, vfy_start, host_end;

    assign REQ_RDY    = (state == IDLE) && BOOT_DONE;
    assign hs         = REQ_VLD && REQ_RDY;
    assign prog_phase = BOOT_DONE && acc_wr && !vfy_phase;
    assign boot_next  = (state == HOLD) && !BOOT_DONE && (boot_idx != 2'd2);
    assign boot_end   = (state == HOLD) && !BOOT_DONE && (boot_idx == 2'd2);
    assign vfy_start  = VERIFY && (state == HOLD) && prog_phase;
    assign host_end   = (state == HOLD) && BOOT_DONE && !vfy_start;

    // Macro controls decode straight from state; gating with RESET drops them asynchronously.
    assign OTP_CS   = !RESET && (state != IDLE);
    assign OTP_READ = !RESET && (state == READ);
    assign OTP_PROG = !RESET && (state == PROG);
    assign OTP_ADDR = RESET ? 7'h00 : addr_q;

    always_ff @(posedge LCLK or posedge RESET) begin
        if (RESET) begin
            state <= SETUP;
            cnt   <= SU_LD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt = prog_phase ? PROG : READ;
                    cnt_nxt   = prog_phase ? PG_LD : RD_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            READ, PROG: begin
                if (cnt == 8'd0) begin
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (boot_next || vfy_start) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SU_LD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (hs) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SU_LD;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge LCLK or posedge RESET) begin
        if (RESET) begin
            boot_idx  <= 2'd0;
            addr_q    <= LCFR_ADDR;
            OTP_DATI  <= 8'h00;
            wdat_q    <= 8'h00;
            acc_wr    <= 1'b0;
            vfy_phase <= 1'b0;
            rd_q      <= 8'h00;
            lcfr_tmp  <= 8'h00;
            hcfr_tmp  <= 8'h00;
            LCFR      <= 8'h00;
            HCFR      <= 8'h00;
            HL_SEL    <= 1'b0;
            BOOT_DONE <= 1'b0;
            RSP_VLD   <= 1'b0;
            RSP_DAT   <= 8'h00;
            RSP_ERR   <= 1'b0;
        end else begin
            RSP_VLD <= host_end;
            if (state == READ && cnt == 8'd0)
                rd_q <= OTP_DATO;
            if (hs) begin
                addr_q    <= REQ_ADDR;
                OTP_DATI  <= REQ_WDAT;
                wdat_q    <= REQ_WDAT;
                acc_wr    <= REQ_WR;
                vfy_phase <= 1'b0;
            end
            if (vfy_start)
                vfy_phase <= 1'b1;
            if (boot_next) begin
                boot_idx <= boot_idx + 2'd1;
                if (boot_idx == 2'd0) begin
                    lcfr_tmp <= rd_q;
                    addr_q   <= HCFR_ADDR;
                end else begin
                    hcfr_tmp <= rd_q;
                    addr_q   <= CFG_ADDR;
                end
            end
            // All trims publish on one edge so ANALOG_TOP never sees a partial set.
            if (boot_end) begin
                LCFR      <= lcfr_tmp;
                HCFR      <= hcfr_tmp;
                HL_SEL    <= rd_q[0];
                BOOT_DONE <= 1'b1;
            end
            if (host_end) begin
                RSP_DAT <= (acc_wr && !VERIFY) ? wdat_q : rd_q;
                // Only bits requested but not set count; OTP cannot clear an already-set bit.
                RSP_ERR <= VERIFY && acc_wr && ((rd_q & wdat_q) != wdat_q);
            end
        end
    end

endmodule

// File: tb/tb_d05200_otp_ctrl.sv
// Directed bench for d05200_otp_ctrl with a 128x8 OTP macro model (OR-programming, optional stuck-at-0 bits at 7'h10).
module tb_d05200_otp_ctrl;

    logic       LCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_VLD = 1'b0;
    logic       REQ_WR = 1'b0;
    logic [6:0] REQ_ADDR = 7'h00;
    logic [7:0] REQ_WDAT = 8'h00;
    logic       REQ_RDY, RSP_VLD, RSP_ERR;
    logic [7:0] RSP_DAT;
    logic       OTP_CS, OTP_READ, OTP_PROG;
    logic [6:0] OTP_ADDR;
    logic [7:0] OTP_DATI, OTP_DATO;
    logic [7:0] LCFR, HCFR;
    logic       HL_SEL, BOOT_DONE;

    logic [7:0] mem [128];
    logic [7:0] stuck = 8'h00;
    int total = 0;
    int bad = 0;

`ifdef OTP_VERIFY_EN
    localparam int  PG_LAT = 211;
    localparam int  PG_RD  = 4;
    localparam bit  VFY    = 1'b1;
`else
    localparam int  PG_LAT = 204;
    localparam int  PG_RD  = 0;
    localparam bit  VFY    = 1'b0;
`endif

    d05200_otp_ctrl dut (
        .LCLK(LCLK), .RESET(RESET),
        .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR), .REQ_WDAT(REQ_WDAT),
        .RSP_VLD(RSP_VLD), .RSP_DAT(RSP_DAT), .RSP_ERR(RSP_ERR),
        .OTP_CS(OTP_CS), .OTP_READ(OTP_READ), .OTP_PROG(OTP_PROG),
        .OTP_ADDR(OTP_ADDR), .OTP_DATI(OTP_DATI), .OTP_DATO(OTP_DATO),
        .LCFR(LCFR), .HCFR(HCFR), .HL_SEL(HL_SEL), .BOOT_DONE(BOOT_DONE)
    );

    always #5 LCLK = ~LCLK;

    assign OTP_DATO = mem[OTP_ADDR] & ~((OTP_ADDR == 7'h10) ? stuck : 8'h00);

    always @(posedge LCLK) begin
        if (OTP_PROG)
            mem[OTP_ADDR] = mem[OTP_ADDR] | OTP_DATI;
    end

    // Issues one request from an IDLE cycle and returns once RSP_VLD is sampled (or the budget expires).
    task automatic do_access(input logic wr, input logic [6:0] a, input logic [7:0] d,
                             output int edges, output int rd_hi, output int pg_hi,
                             output int unstable, output int overlap);
        logic [6:0] a0;
        logic [7:0] d0;
        REQ_VLD = 1'b1; REQ_WR = wr; REQ_ADDR = a; REQ_WDAT = d;
        @(posedge LCLK); #1;
        REQ_VLD = 1'b0;
        edges = 1; rd_hi = 0; pg_hi = 0; unstable = 0; overlap = 0;
        a0 = OTP_ADDR; d0 = OTP_DATI;
        while (RSP_VLD !== 1'b1 && edges < 400) begin
            if (OTP_READ) rd_hi++;
            if (OTP_PROG) pg_hi++;
            if (OTP_READ && OTP_PROG) overlap++;
            if (OTP_CS && (OTP_ADDR !== a0 || OTP_DATI !== d0)) unstable++;
            @(posedge LCLK); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        logic [46:0] v;
        repeat (2) @(posedge LCLK);
        #1;
        v = {OTP_CS, OTP_READ, OTP_PROG, OTP_ADDR, OTP_DATI, REQ_RDY, RSP_VLD,
             RSP_DAT, RSP_ERR, LCFR, HCFR, HL_SEL, BOOT_DONE};
        total++;
        if (v !== 47'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", v); end
    endtask

    // REQ_VLD is held high through boot to check backpressure.
    task automatic test_boot(input logic [7:0] exp_hcfr);
        int n = 0, rdy_early = 0, sh_early = 0, rsp_seen = 0;
        REQ_VLD = 1'b1; REQ_WR = 1'b0; REQ_ADDR = 7'h45;
        @(negedge LCLK);
        RESET = 1'b0;
        do begin
            @(posedge LCLK); #1;
            n++;
            if (RSP_VLD) rsp_seen++;
            if (!BOOT_DONE) begin
                if (REQ_RDY) rdy_early++;
                if (LCFR != 0 || HCFR != 0 || HL_SEL) sh_early++;
            end
        end while (!BOOT_DONE && n < 100);
        total++;
        if (n !== 21) begin bad++; $display("FAIL boot_len got=%0d want=21", n); end
        total++;
        if (LCFR !== 8'hA5) begin bad++; $display("FAIL boot_lcfr got=%h want=a5", LCFR); end
        total++;
        if (HCFR !== exp_hcfr) begin bad++; $display("FAIL boot_hcfr got=%h want=%h", HCFR, exp_hcfr); end
        total++;
        if (HL_SEL !== 1'b1) begin bad++; $display("FAIL boot_hlsel got=%b want=1", HL_SEL); end
        total++;
        if (sh_early !== 0) begin bad++; $display("FAIL boot_shadow_early got=%0d want=0", sh_early); end
        total++;
        if (rdy_early !== 0) begin bad++; $display("FAIL boot_rdy_early got=%0d want=0", rdy_early); end
        total++;
        if (rsp_seen !== 0) begin bad++; $display("FAIL boot_rsp got=%0d want=0", rsp_seen); end
        total++;
        if (REQ_RDY !== 1'b1) begin bad++; $display("FAIL boot_rdy got=%b want=1", REQ_RDY); end
        REQ_VLD = 1'b0;
    endtask

    task automatic test_host_read;
        int e, r, p, u, o;
        do_access(1'b0, 7'h45, 8'h00, e, r, p, u, o);
        total++;
        if (e !== 8) begin bad++; $display("FAIL rd_latency got=%0d want=8", e); end
        total++;
        if (r !== 4 || p !== 0 || o !== 0) begin
            bad++; $display("FAIL rd_pulses got read=%0d prog=%0d both=%0d want 4/0/0", r, p, o);
        end
        total++;
        if (RSP_DAT !== 8'h5A || RSP_ERR !== 1'b0) begin
            bad++; $display("FAIL rd_data got=%h err=%b want=5a err=0", RSP_DAT, RSP_ERR);
        end
        @(posedge LCLK); #1;
        total++;
        if (RSP_VLD !== 1'b0 || RSP_DAT !== 8'h5A || OTP_CS !== 1'b0) begin
            bad++; $display("FAIL rd_after got vld=%b dat=%h cs=%b want 0/5a/0", RSP_VLD, RSP_DAT, OTP_CS);
        end
    endtask

    task automatic test_verify_fail;
        int e, r, p, u, o;
        logic [7:0] exp_dat;
        logic       exp_err;
        exp_dat = VFY ? 8'h00 : 8'h80;
        exp_err = VFY;
        stuck = 8'h80;
        do_access(1'b1, 7'h10, 8'h80, e, r, p, u, o);
        stuck = 8'h00;
        total++;
        if (e !== PG_LAT || p !== 200 || r !== PG_RD) begin
            bad++; $display("FAIL vfy_timing got lat=%0d prog=%0d read=%0d want %0d/200/%0d", e, p, r, PG_LAT, PG_RD);
        end
        total++;
        if (RSP_DAT !== exp_dat || RSP_ERR !== exp_err) begin
            bad++; $display("FAIL vfy_result got dat=%h err=%b want dat=%h err=%b", RSP_DAT, RSP_ERR, exp_dat, exp_err);
        end
    endtask

    task automatic test_host_prog;
        int e, r, p, u, o;
        do_access(1'b1, 7'h10, 8'hF0, e, r, p, u, o);
        total++;
        if (e !== PG_LAT) begin bad++; $display("FAIL pg_latency got=%0d want=%0d", e, PG_LAT); end
        total++;
        if (p !== 200 || r !== PG_RD || o !== 0) begin
            bad++; $display("FAIL pg_pulses got prog=%0d read=%0d both=%0d want 200/%0d/0", p, r, o, PG_RD);
        end
        total++;
        if (u !== 0) begin bad++; $display("FAIL pg_addr_stable got=%0d want=0", u); end
        total++;
        if (RSP_DAT !== 8'hF0 || RSP_ERR !== 1'b0) begin
            bad++; $display("FAIL pg_rsp got dat=%h err=%b want f0/0", RSP_DAT, RSP_ERR);
        end
    endtask

    task automatic test_boot_addr;
        int e, r, p, u, o;
        do_access(1'b1, 7'h01, 8'h0F, e, r, p, u, o);
        total++;
        if (HCFR !== 8'h3C || LCFR !== 8'hA5) begin
            bad++; $display("FAIL shadow_hold got hcfr=%h lcfr=%h want 3c/a5", HCFR, LCFR);
        end
        do_access(1'b0, 7'h01, 8'h00, e, r, p, u, o);
        total++;
        if (RSP_DAT !== 8'h3F || e !== 8) begin
            bad++; $display("FAIL boot_addr_raw got dat=%h lat=%0d want 3f/8", RSP_DAT, e);
        end
    endtask

    task automatic test_back_to_back;
        int n = 1, m = 1, rdy_bad = 0;
        REQ_VLD = 1'b1; REQ_WR = 1'b0; REQ_ADDR = 7'h45;
        @(posedge LCLK); #1;
        REQ_ADDR = 7'h00;
        while (RSP_VLD !== 1'b1 && n < 50) begin
            if (REQ_RDY) rdy_bad++;
            @(posedge LCLK); #1;
            n++;
        end
        total++;
        if (n !== 8 || RSP_DAT !== 8'h5A || rdy_bad !== 0) begin
            bad++; $display("FAIL b2b_first got lat=%0d dat=%h rdy_busy=%0d want 8/5a/0", n, RSP_DAT, rdy_bad);
        end
        total++;
        if (REQ_RDY !== 1'b1) begin bad++; $display("FAIL b2b_rdy got=%b want=1", REQ_RDY); end
        @(posedge LCLK); #1;
        REQ_VLD = 1'b0;
        total++;
        if (OTP_CS !== 1'b1 || OTP_ADDR !== 7'h00 || RSP_VLD !== 1'b0) begin
            bad++; $display("FAIL b2b_start got cs=%b addr=%h vld=%b want 1/00/0", OTP_CS, OTP_ADDR, RSP_VLD);
        end
        while (RSP_VLD !== 1'b1 && m < 50) begin
            @(posedge LCLK); #1;
            m++;
        end
        total++;
        if (m !== 8 || RSP_DAT !== 8'hA5) begin
            bad++; $display("FAIL b2b_second got lat=%0d dat=%h want 8/a5", m, RSP_DAT);
        end
    endtask

    task automatic test_reset_mid_prog;
        int pc = 0, guard = 0;
        REQ_VLD = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 7'h20; REQ_WDAT = 8'h55;
        @(posedge LCLK); #1;
        REQ_VLD = 1'b0;
        while (pc < 50 && guard < 300) begin
            if (OTP_PROG) pc++;
            if (pc < 50) begin
                @(posedge LCLK); #1;
                guard++;
            end
        end
        total++;
        if (pc !== 50) begin bad++; $display("FAIL rst_prog_reach got=%0d want=50", pc); end
        #2;
        RESET = 1'b1;
        #1;
        total++;
        if (OTP_PROG !== 1'b0 || OTP_CS !== 1'b0) begin
            bad++; $display("FAIL rst_async got prog=%b cs=%b want 0/0", OTP_PROG, OTP_CS);
        end
        total++;
        if (LCFR !== 8'h00 || HCFR !== 8'h00 || HL_SEL !== 1'b0 || BOOT_DONE !== 1'b0) begin
            bad++; $display("FAIL rst_shadow got lcfr=%h hcfr=%h hl=%b done=%b want all 0", LCFR, HCFR, HL_SEL, BOOT_DONE);
        end
        repeat (2) @(posedge LCLK);
        test_boot(8'h3F);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h00] = 8'hA5;
        mem[7'h01] = 8'h3C;
        mem[7'h02] = 8'h01;
        mem[7'h45] = 8'h5A;
        test_reset;
        test_boot(8'h3C);
        test_host_read;
        test_verify_fail;
        test_host_prog;
        test_boot_addr;
        test_back_to_back;
        test_reset_mid_prog;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d05200_otp_ctrl.md
# d05200_otp_ctrl

OTP access controller inside `d05200_dc_top` that drives the 128x8 OTP macro pins (`OTP_CS`, `OTP_READ`, `OTP_PROG`, `OTP_ADDR`, `OTP_DATI`, `OTP_DATO`). After reset it boot-loads the analog trim bytes into shadow registers that feed `ANALOG_TOP` (`LCFR`, `HCFR`, `HL_SEL`). It then serves single-byte read and program requests from the digital-core host logic.

## Interface
- `SU_CYC`, 2: cycles from `OTP_CS`/`OTP_ADDR` valid to the `OTP_READ`/`OTP_PROG` pulse; must be ≥1.
- `RD_CYC`, 4: `OTP_READ` pulse width in cycles; must be ≥1.
- `PG_CYC`, 200: `OTP_PROG` pulse width in cycles; must be ≥1 and ≤255.
- `LCFR_ADDR`, 7'h00: OTP address of the LCFR trim byte.
- `HCFR_ADDR`, 7'h01: OTP address of the HCFR trim byte.
- `CFG_ADDR`, 7'h02: OTP address of the config byte; bit0 is `HL_SEL`.

Ports:
- `LCLK` in 1: the block's only clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `REQ_VLD` in 1: host request valid.
- `REQ_RDY` out 1: controller can accept a request.
- `REQ_WR` in 1: 1 = program, 0 = read.
- `REQ_ADDR` in 7: request address.
- `REQ_WDAT` in 8: program data.
- `RSP_VLD` out 1: one-cycle response strobe.
- `RSP_DAT` out 8: read data, or program data / read-back value.
- `RSP_ERR` out 1: program verify mismatch (see Configuration).
- `OTP_CS`, `OTP_READ`, `OTP_PROG` out 1 each: OTP macro controls.
- `OTP_ADDR` out 7, `OTP_DATI` out 8: OTP macro address and program data.
- `OTP_DATO` in 8: OTP macro read data.
- `LCFR` out 8, `HCFR` out 8, `HL_SEL` out 1: trim shadow registers.
- `BOOT_DONE` out 1: shadows are valid.

## Operation
- FSM states: `SETUP`, `READ`, `PROG`, `HOLD`, `IDLE`; an 8-bit down-counter times each state.
- Reset state is `SETUP` with boot index 0. Boot performs three reads in order: `LCFR_ADDR`, `HCFR_ADDR`, `CFG_ADDR`.
- Each access runs `SETUP` (`SU_CYC` cycles) → `READ` (`RD_CYC`) or `PROG` (`PG_CYC`) → `HOLD` (1 cycle) → next.
  - `OTP_CS`=1 throughout the access.
  - `OTP_ADDR` and `OTP_DATI` are registered at access start and held stable while `OTP_CS`=1.
  - `OTP_READ`=1 only in `READ`; `OTP_PROG`=1 only in `PROG`. The two are never high together.
  - `OTP_DATO` is sampled on the clock edge that ends the last `READ` cycle.
- Boot reads fill internal shadows and produce no `RSP_VLD`.
- After the third `HOLD`, `LCFR`, `HCFR`, `HL_SEL` and `BOOT_DONE` all update together on the same edge, and the FSM enters `IDLE`.
- In `IDLE`: `OTP_CS`=0, and `REQ_RDY`=`BOOT_DONE`. A handshake (`REQ_VLD` & `REQ_RDY`) starts an access.
- `REQ_RDY` is 0 in every state other than `IDLE`. Request inputs outside a handshake are ignored.
- At the end of `HOLD` of a host access, the FSM returns to `IDLE`.
  - In that same cycle `RSP_VLD`=1 for exactly one cycle, with `RSP_DAT` valid.
  - `REQ_RDY`=1 in that same cycle, so back-to-back requests are accepted.
- Host reads of the boot addresses return raw OTP data. Host programs of the boot addresses do not update the shadows; shadows reload only on reset.
- `RSP_DAT` and `RSP_ERR` hold their value until the next response.
- `RESET` asserted mid-access:
  - All outputs drop to reset values immediately (asynchronous), which aborts any `OTP_PROG` pulse.
  - Boot restarts on release.

## Timing
- Reset values: every output is 0 (`OTP_*` controls, `OTP_ADDR`, `OTP_DATI`, `REQ_RDY`, `RSP_*`, `LCFR`, `HCFR`, `HL_SEL`, `BOOT_DONE`).
- Boot length is 3×(`SU_CYC`+`RD_CYC`+1) cycles from the first `LCLK` edge after `RESET` deasserts; 21 cycles with defaults.
- Read latency is `SU_CYC`+`RD_CYC`+2 edges from the handshake edge to `RSP_VLD`; 8 with defaults.
- Program latency is `SU_CYC`+`PG_CYC`+2 edges; 204 with defaults. With `OTP_VERIFY_EN`, add `SU_CYC`+`RD_CYC`+1.
- On a handshake, `OTP_CS` rises on the next edge.
- `OTP_CS` falls on the edge that returns the FSM to `IDLE`, unless a new handshake occurs in that `IDLE` cycle.

## Configuration
- `OTP_VERIFY_EN` defined:
  - After each host program's `HOLD`, the controller automatically performs a read (`SETUP`/`READ`/`HOLD`) of the same address.
  - `RSP_DAT` = read-back value.
  - `RSP_ERR` = 1 if (read-back & `REQ_WDAT`) ≠ `REQ_WDAT`, i.e. an OTP bit failed to program. Already-set bits are not an error.
- `OTP_VERIFY_EN` undefined:
  - No read-back is performed.
  - `RSP_DAT` = `REQ_WDAT`, and `RSP_ERR` is tied to 0.
- Reads never assert `RSP_ERR`.

## Test plan
- Boot load: OTP model holds [00]=8'hA5, [01]=8'h3C, [02]=8'h01; release `RESET` → `BOOT_DONE`, `LCFR`=A5, `HCFR`=3C and `HL_SEL`=1 all rise on edge 21, with no `RSP_VLD` pulse.
- Host read: read addr 7'h45 holding 8'h5A → `OTP_READ` high exactly 4 cycles; `RSP_VLD` 8 edges after the handshake with `RSP_DAT`=5A.
- Host program: program addr 7'h10 with 8'hF0 → `OTP_PROG` high exactly 200 cycles; `OTP_ADDR`/`OTP_DATI` stable while `OTP_CS`=1; `RSP_VLD` at edge 204 without the macro, or edge 211 with `OTP_VERIFY_EN` and `RSP_ERR`=0.
- Verify fail (`OTP_VERIFY_EN`): model forces bit7 of addr 7'h10 stuck at 0; program 8'h80 → `RSP_ERR`=1, `RSP_DAT`=00.
- Back-to-back/backpressure: `REQ_VLD` held high from reset → `REQ_RDY` stays 0 until `BOOT_DONE`; two consecutive reads are accepted, the second in the `RSP_VLD` cycle of the first.
- Reset mid-program: assert `RESET` at `PROG` cycle 50 → `OTP_PROG`/`OTP_CS` drop asynchronously, shadows clear to 0, and the full boot sequence repeats after release.
